// File: rtl/stopwatch_core.sv
// ---------------------------------------------------------------------------
// stopwatch_core
//   Single-clock MM:SS stopwatch / count-down timer with a built-in 4-digit
//   7-segment scanner. Every rate is derived from clock enables on clk.
//   The time is kept as four BCD digits. Seconds are 00..59 and minutes are
//   00..MAX_MIN, where MAX_MIN is 1..99.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous reset, active low
//   adj      in   async level, 1 = adjust mode
//   sel      in   async level, field to adjust: 0 = minutes, 1 = seconds
//   pause    in   async button, rising edge toggles run/pause
//   lap      in   async button, rising edge toggles display freeze
//   down     in   async level, 1 = count down, 0 = count up
//   cathode  out  segments {g,f,e,d,c,b,a}, registered
//   anode    out  digit enables, registered; [0] = sec ones .. [3] = min tens
//   done     out  count-down has reached 00:00
//   running  out  stopwatch is counting
// ---------------------------------------------------------------------------
module stopwatch_core #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int REFRESH_HZ     = 1000,
  parameter int ADJ_HZ         = 2,
  parameter int BLINK_HZ       = 2,
  parameter int MAX_MIN        = 59,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adj,
  input  logic       sel,
  input  logic       pause,
  input  logic       lap,
  input  logic       down,
  output logic [6:0] cathode,
  output logic [3:0] anode,
  output logic       done,
  output logic       running
);

  typedef enum logic [1:0] {ST_PAUSED, ST_RUN, ST_ADJUST, ST_DONE} state_t;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } time_t;

  // Divisors use integer division and are never less than 1.
  localparam int DIV_1S   = (CLK_HZ < 1) ? 1 : CLK_HZ;
  localparam int DIV_ADJ  = (CLK_HZ / ADJ_HZ < 1) ? 1 : CLK_HZ / ADJ_HZ;
  localparam int DIV_SCAN = (CLK_HZ / REFRESH_HZ < 1) ? 1 : CLK_HZ / REFRESH_HZ;
  localparam int DIV_BLNK = (CLK_HZ / (2 * BLINK_HZ) < 1) ? 1 : CLK_HZ / (2 * BLINK_HZ);
  localparam int W_1S     = (DIV_1S   > 1) ? $clog2(DIV_1S)   : 1;
  localparam int W_ADJ    = (DIV_ADJ  > 1) ? $clog2(DIV_ADJ)  : 1;
  localparam int W_SCAN   = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
  localparam int W_BLNK   = (DIV_BLNK > 1) ? $clog2(DIV_BLNK) : 1;

  localparam logic [3:0] MAX_M1  = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M0  = 4'(MAX_MIN % 10);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] DIG_OFF = SEG_ACTIVE_LOW ? 4'hF  : 4'h0;

  // Seconds-only increment. It wraps 59 -> 00 and never touches the minutes.
  function automatic time_t inc_sec(input time_t t);
    time_t r;
    r = t;
    if (t.s0 != 4'd9) r.s0 = t.s0 + 4'd1;
    else begin
      r.s0 = 4'd0;
      r.s1 = (t.s1 == 4'd5) ? 4'd0 : t.s1 + 4'd1;
    end
    return r;
  endfunction

  // Minutes-only increment. It wraps MAX_MIN -> 00.
  function automatic time_t inc_min(input time_t t);
    time_t r;
    r = t;
    if (t.m1 == MAX_M1 && t.m0 == MAX_M0) begin
      r.m1 = 4'd0;
      r.m0 = 4'd0;
    end else if (t.m0 == 4'd9) begin
      r.m1 = t.m1 + 4'd1;
      r.m0 = 4'd0;
    end else r.m0 = t.m0 + 4'd1;
    return r;
  endfunction

  function automatic time_t step_up(input time_t t);
    time_t r;
    r = inc_sec(t);
    if (t.s1 == 4'd5 && t.s0 == 4'd9) r = inc_min(r);
    return r;
  endfunction

  // This function is only called with a non-zero time.
  function automatic time_t step_down(input time_t t);
    time_t r;
    r = t;
    if (t.s0 != 4'd0) r.s0 = t.s0 - 4'd1;
    else begin
      r.s0 = 4'd9;
      if (t.s1 != 4'd0) r.s1 = t.s1 - 4'd1;
      else begin
        r.s1 = 4'd5;
        if (t.m0 != 4'd0) r.m0 = t.m0 - 4'd1;
        else begin
          r.m0 = 4'd9;
          r.m1 = t.m1 - 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = 7'h3F;  4'd1: glyph = 7'h06;  4'd2: glyph = 7'h5B;
      4'd3: glyph = 7'h4F;  4'd4: glyph = 7'h66;  4'd5: glyph = 7'h6D;
      4'd6: glyph = 7'h7D;  4'd7: glyph = 7'h07;  4'd8: glyph = 7'h7F;
      4'd9: glyph = 7'h6F;  default: glyph = 7'h00;
    endcase
  endfunction

  // The synchroniser bit order is {down, lap, pause, sel, adj}.
  // The edge history bit order is {lap, pause}.
  logic [4:0]        meta_q, sync_q;
  logic [1:0]        prev_q;
  logic              adj_s, sel_s, pause_s, lap_s, down_s, pause_edge, lap_edge;
  logic [W_1S-1:0]   cnt_1s_q, cnt_1s_d;
  logic [W_ADJ-1:0]  cnt_adj_q, cnt_adj_d;
  logic [W_SCAN-1:0] cnt_scan_q, cnt_scan_d;
  logic [W_BLNK-1:0] cnt_blnk_q, cnt_blnk_d;
  logic              tick_1s, tick_adj, tick_scan, tick_blnk;
  logic              blink_q, blink_d;
  logic [1:0]        idx_q, idx_d;
  state_t            state_q, state_d;
  time_t             time_q, time_d, lap_time_q, lap_time_d, disp;
  logic              frz_q, frz_d, done_q, done_d, running_q, running_d, blank;
  logic [3:0]        digit;
  logic [6:0]        cathode_q, cathode_d;
  logic [3:0]        anode_q, anode_d;

  assign {down_s, lap_s, pause_s, sel_s, adj_s} = sync_q;
  assign pause_edge = pause_s & ~prev_q[0];
  assign lap_edge   = lap_s & ~prev_q[1];

  assign tick_1s   = (cnt_1s_q   == W_1S'(DIV_1S - 1));
  assign tick_adj  = (cnt_adj_q  == W_ADJ'(DIV_ADJ - 1));
  assign tick_scan = (cnt_scan_q == W_SCAN'(DIV_SCAN - 1));
  assign tick_blnk = (cnt_blnk_q == W_BLNK'(DIV_BLNK - 1));

  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path leaves it unassigned, which would infer a latch.
    cnt_adj_d  = tick_adj  ? '0 : cnt_adj_q + 1'b1;
    cnt_scan_d = tick_scan ? '0 : cnt_scan_q + 1'b1;
    cnt_blnk_d = tick_blnk ? '0 : cnt_blnk_q + 1'b1;
    blink_d    = blink_q ^ tick_blnk;
    idx_d      = tick_scan ? idx_q + 2'd1 : idx_q;
    state_d    = state_q;
    time_d     = time_q;
    frz_d      = frz_q;
    lap_time_d = lap_time_q;

    if (adj_s) begin
      state_d = ST_ADJUST;
      frz_d   = 1'b0;
      if (tick_adj) time_d = sel_s ? inc_sec(time_q) : inc_min(time_q);
    end else begin
      unique case (state_q)
        ST_PAUSED: if (pause_edge && !(down_s && time_q == '0)) state_d = ST_RUN;
        ST_RUN: begin
          if (tick_1s) begin
            if (!down_s) time_d = step_up(time_q);
            else begin
              time_d = (time_q == '0) ? '0 : step_down(time_q);
              if (time_d == '0) state_d = ST_DONE;
            end
          end
          // If a pause edge and a tick arrive together, the time steps first and then the pause takes effect.
          if (pause_edge) state_d = ST_PAUSED;
        end
        ST_ADJUST: state_d = ST_PAUSED;
        ST_DONE:   if (pause_edge) state_d = ST_PAUSED;
      endcase
      if (lap_edge && (state_q == ST_RUN || state_q == ST_PAUSED)) begin
        frz_d = ~frz_q;
        if (!frz_q) lap_time_d = time_q;
      end
      if (state_d == ST_DONE) frz_d = 1'b0;
    end

    // When the stopwatch enters RUN, the 1 s count restarts so that the first second is full length.
    cnt_1s_d = tick_1s ? '0 : cnt_1s_q + 1'b1;
    if (state_d == ST_RUN && state_q != ST_RUN) cnt_1s_d = '0;

    done_d    = (state_d == ST_DONE);
    running_d = (state_d == ST_RUN);
  end

  always_comb begin
    disp = frz_q ? lap_time_q : time_q;
    case (idx_q)
      2'd0:    digit = disp.s0;
      2'd1:    digit = disp.s1;
      2'd2:    digit = disp.m0;
      default: digit = disp.m1;
    endcase
    // The digit blinks in DONE. In ADJUST, only the two digits of the field being adjusted blink.
    // The condition idx_q[1] != sel_s selects those two digits.
    blank     = blink_q && (state_q == ST_DONE ||
                            (state_q == ST_ADJUST && (idx_q[1] != sel_s)));
    cathode_d = blank ? 7'h00 : glyph(digit);
    anode_d   = blank ? 4'h0  : (4'b0001 << idx_q);
    if (SEG_ACTIVE_LOW) begin
      cathode_d = ~cathode_d;
      anode_d   = ~anode_d;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so every flop samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q     <= '0;
      sync_q     <= '0;
      prev_q     <= '0;
      cnt_1s_q   <= '0;
      cnt_adj_q  <= '0;
      cnt_scan_q <= '0;
      cnt_blnk_q <= '0;
      blink_q    <= 1'b0;
      idx_q      <= '0;
      state_q    <= ST_PAUSED;
      time_q     <= '0;
      lap_time_q <= '0;
      frz_q      <= 1'b0;
      done_q     <= 1'b0;
      running_q  <= 1'b0;
      cathode_q  <= SEG_OFF;
      anode_q    <= DIG_OFF;
    end else begin
      meta_q     <= {down, lap, pause, sel, adj};
      sync_q     <= meta_q;
      prev_q     <= {lap_s, pause_s};
      cnt_1s_q   <= cnt_1s_d;
      cnt_adj_q  <= cnt_adj_d;
      cnt_scan_q <= cnt_scan_d;
      cnt_blnk_q <= cnt_blnk_d;
      blink_q    <= blink_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      time_q     <= time_d;
      lap_time_q <= lap_time_d;
      frz_q      <= frz_d;
      done_q     <= done_d;
      running_q  <= running_d;
      cathode_q  <= cathode_d;
      anode_q    <= anode_d;
    end
  end

  assign cathode = cathode_q;
  assign anode   = anode_q;
  assign done    = done_q;
  assign running = running_q;

endmodule
